// File: rtl/fp_normalize.sv
// Iterative normalizer for the FP adder: carry right shift on accept, then one-bit left shifts.
// Build option: define FP_ROUND_NEAREST_EN to round the carry shift to nearest-even instead of truncating.
`timescale 1ns/1ps

package fp;
    localparam int FRACTION_BITS = 23;
    localparam int EXPONENT_BITS = 8;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_BITS-1:0] exponent;
        logic [FRACTION_BITS-1:0] fraction;
    } float;
endpackage

module fp_normalize (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [fp::FRACTION_BITS+1:0] sum,
    input  logic [fp::EXPONENT_BITS-1:0] exp_in,
    input  logic                         sign_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output fp::float                     result,
    output logic                         overflow
);
    localparam int F = fp::FRACTION_BITS;
    localparam int E = fp::EXPONENT_BITS;
    localparam logic [E:0] EXP_ONE = {{E{1'b0}}, 1'b1};
    localparam logic [E:0] EXP_MAX = {1'b0, {E{1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t       state;
    logic [F+1:0] sig;
    logic [F+1:0] load_sig;
    logic [E:0]   exp;
    logic [E:0]   exp_base;
    logic [E:0]   load_exp;
    logic         sgn;

    assign in_ready = (state == IDLE);

    // Values loaded on acceptance, with the carry right shift already applied.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so later statements see earlier results and no latch is inferred.
    always_comb begin
        exp_base = (exp_in == '0) ? EXP_ONE : {1'b0, exp_in};
        load_sig = sum;
        load_exp = exp_base;
        if (sum[F+1]) begin
`ifdef FP_ROUND_NEAREST_EN
            // sum[0] is the guard bit, sum[1] the kept LSB: ties round to even.
            load_sig = (sum >> 1) + {{(F+1){1'b0}}, sum[1] & sum[0]};
            load_exp = exp_base + EXP_ONE;
            if (load_sig[F+1]) begin
                load_sig = load_sig >> 1;
                load_exp = load_exp + EXP_ONE;
            end
`else
            load_sig = sum >> 1;
            load_exp = exp_base + EXP_ONE;
`endif
        end
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sig       <= '0;
            exp       <= '0;
            sgn       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sig      <= load_sig;
                        exp      <= load_exp;
                        sgn      <= sign_in;
                        overflow <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (sig == '0) begin
                        result    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp >= EXP_MAX) begin
                        // Saturate to infinity; the wide exponent may sit just past all-ones.
                        result    <= '{sign: sgn, exponent: '1, fraction: '0};
                        overflow  <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sig[F]) begin
                        result    <= '{sign: sgn, exponent: exp[E-1:0], fraction: sig[F-1:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp == EXP_ONE) begin
                        result    <= '{sign: sgn, exponent: '0, fraction: sig[F-1:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sig <= sig << 1;
                        exp <= exp - EXP_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
